// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses SYNC CMD LEN payload CHK frames from a UART byte stream,
// replays validated payload as config writes and queues a one-byte response.
module uart_cmd_parser #(
    parameter int         MAX_LEN        = 40,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC           = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_new,
    output logic [7:0] cmd,
    output logic [7:0] cfg_data,
    output logic [5:0] cfg_index,
    output logic       cfg_wr,
    output logic       frame_done,
    output logic       frame_error,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_ready,
    output logic       busy
);

    localparam int            AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_B   = 8'(MAX_LEN);
    localparam logic [7:0]    ACK     = 8'h06;
    localparam logic [7:0]    NAK     = 8'h15;
    localparam logic [7:0]    OVF     = 8'h16;
    localparam logic [7:0]    TMO     = 8'h17;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHECK,
        S_WRITE, S_DONE, S_RESP, S_RESP_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic          rx_prev, byte_ok, timed, expire;
    logic          emit, set_done, set_err, load_code;
    logic [7:0]    code, chk;
    logic [6:0]    len, pidx, widx;
    logic [TW-1:0] tout;
    logic [7:0]    mem [MAX_LEN];

    assign byte_ok = rx_new && !rx_prev && !rst;
    assign timed   = (state == S_CMD) || (state == S_LEN) ||
                     (state == S_PAYLOAD) || (state == S_CHECK);
    assign expire  = timed && !byte_ok && (tout >= TO_LAST);
    assign busy    = (state != S_IDLE);
    assign tx_send = (state == S_RESP) && tx_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the per-cycle write/done/error/response decisions
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        load_code = 1'b0;
        code      = ACK;
        unique case (state)
            S_IDLE:
                if (byte_ok && rx_data == SYNC) state_nxt = S_CMD;
            S_CMD:
                if (byte_ok) state_nxt = S_LEN;
            S_LEN:
                if (byte_ok) begin
                    if (rx_data > MAX_B) begin
                        set_err   = 1'b1;
                        load_code = 1'b1;
                        code      = OVF;
                        state_nxt = S_RESP;
                    end else if (rx_data == 8'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            S_PAYLOAD:
                if (byte_ok && pidx == len - 7'd1) state_nxt = S_CHECK;
            S_CHECK:
                if (byte_ok) begin
                    load_code = 1'b1;
                    if (rx_data != chk) begin
                        set_err   = 1'b1;
                        code      = NAK;
                        state_nxt = S_RESP;
                    end else if (len == 7'd0) begin
                        set_done  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        emit      = 1'b1;
                        state_nxt = S_WRITE;
                    end
                end
            S_WRITE:
                if (widx == len) begin
                    set_done  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    emit = 1'b1;
                end
            S_DONE:
                state_nxt = S_RESP;
            S_RESP:
                if (tx_ready) state_nxt = S_RESP_HOLD;
            S_RESP_HOLD:
                if (!tx_ready) state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
        if (expire) begin
            set_err   = 1'b1;
            load_code = 1'b1;
            code      = TMO;
            state_nxt = S_RESP;
        end
    end

    // Edge detect, frame fields, checksum, timeout and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev     <= 1'b0;
            cmd         <= 8'd0;
            cfg_data    <= 8'd0;
            cfg_index   <= 6'd0;
            cfg_wr      <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            tx_data     <= 8'd0;
            tout        <= '0;
            chk         <= 8'd0;
            len         <= 7'd0;
            pidx        <= 7'd0;
            widx        <= 7'd0;
        end else begin
            rx_prev     <= rx_new;
            cfg_wr      <= emit;
            frame_done  <= set_done;
            frame_error <= set_err;
            if (load_code) tx_data <= code;
            if (byte_ok)    tout <= TW'(1);
            else if (timed) tout <= tout + TW'(1);
            else            tout <= '0;
            if (state == S_IDLE) begin
                pidx <= 7'd0;
                widx <= 7'd0;
            end
            if (emit) begin
                cfg_data  <= mem[widx[AW-1:0]];
                cfg_index <= widx[5:0];
                widx      <= widx + 7'd1;
            end
            if (byte_ok && state == S_CMD) begin
                cmd <= rx_data;
                chk <= rx_data;
            end
            if (byte_ok && state == S_LEN) begin
                len <= rx_data[6:0];
                chk <= chk ^ rx_data;
            end
            if (byte_ok && state == S_PAYLOAD) begin
                pidx <= pidx + 7'd1;
                chk  <= chk ^ rx_data;
            end
        end
    end

    // Payload buffer; unreset, and only indices below the current LEN are read
    always_ff @(posedge clk) begin
        if (byte_ok && state == S_PAYLOAD) mem[pidx[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: scoreboard bench for uart_cmd_parser
// (MAX_LEN=40, TIMEOUT_CYCLES=100).
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_new = 1'b0;
    logic       tx_ready;
    logic [7:0] cmd, cfg_data, tx_data;
    logic [5:0] cfg_index;
    logic       cfg_wr, frame_done, frame_error, tx_send, busy;

    typedef struct {
        logic [5:0] idx;
        logic [7:0] data;
        int         rel;
    } wr_t;

    typedef struct {
        logic [1:0] kind;
        int         rel;
    } ev_t;

    wr_t        wr_q[$];
    ev_t        ev_q[$];
    logic [7:0] rs_q[$];
    logic [7:0] pay[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;
    int   tx_cnt = 0;
    logic send_seen = 1'b0;
    logic tx_block = 1'b0;
    bit   ok;

    assign tx_ready = (tx_cnt == 0) && !tx_block;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .MAX_LEN(40),
        .TIMEOUT_CYCLES(100),
        .SYNC(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_new(rx_new),
        .cmd(cmd),
        .cfg_data(cfg_data),
        .cfg_index(cfg_index),
        .cfg_wr(cfg_wr),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_ready(tx_ready),
        .busy(busy)
    );

    function automatic int pending();
        return wr_q.size() + ev_q.size() + rs_q.size();
    endfunction

    task automatic cycle_loop();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // transmitter: busy for 4 cycles after each accepted request
    task automatic tx_model();
        forever begin
            @(posedge clk);
            #1;
            if (rst)            tx_cnt = 0;
            else if (send_seen) tx_cnt = 4;
            else if (tx_cnt > 0) tx_cnt--;
        end
    endtask

    task automatic mon_loop();
        wr_t        w;
        ev_t        e;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            send_seen = tx_send;
            if (!rst) begin
                if (cfg_wr) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL cfg_wr_unexpected got idx=%0d data=%02h required none",
                                 cfg_index, cfg_data);
                    end else begin
                        w = wr_q.pop_front();
                        if (cfg_index !== w.idx || cfg_data !== w.data ||
                            cyc != last_edge + w.rel) begin
                            errors++;
                            $display("FAIL cfg_wr got idx=%0d data=%02h cyc=%0d required idx=%0d data=%02h cyc=%0d",
                                     cfg_index, cfg_data, cyc, w.idx, w.data, last_edge + w.rel);
                        end
                    end
                end
                if (frame_done || frame_error) begin
                    checks++;
                    if (ev_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_event_unexpected got done=%0b err=%0b required none",
                                 frame_done, frame_error);
                    end else begin
                        e = ev_q.pop_front();
                        if ({frame_done, frame_error} !== e.kind ||
                            (e.rel >= 0 && cyc != last_edge + e.rel)) begin
                            errors++;
                            $display("FAIL frame_event got done_err=%b cyc=%0d required done_err=%b cyc=%0d",
                                     {frame_done, frame_error}, cyc, e.kind, last_edge + e.rel);
                        end
                    end
                end
                if (tx_send) begin
                    checks++;
                    if (rs_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_send_unexpected got tx_data=%02h required none", tx_data);
                    end else begin
                        r = rs_q.pop_front();
                        if (tx_data !== r || tx_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL tx_send got tx_data=%02h tx_ready=%0b required tx_data=%02h tx_ready=1",
                                     tx_data, tx_ready, r);
                        end
                    end
                end
            end
        end
    endtask

    // one rising edge of rx_new, held for `hold` cycles, low for >= gap+1
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk);
        #1;
        rx_data   = b;
        rx_new    = 1'b1;
        last_edge = cyc;
        repeat (hold) @(posedge clk);
        #1 rx_new = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // sends SYNC CMD LEN pay[] CHK and queues what the parser must produce
    task automatic send_frame(input logic [7:0] c, input logic [7:0] len,
                              input bit corrupt, input int hold);
        logic [7:0] chk;
        chk = c ^ len;
        foreach (pay[i]) chk ^= pay[i];
        if (corrupt) chk ^= 8'h01;
        if (len > 8'd40) begin
            ev_q.push_back('{2'b01, -1});
            rs_q.push_back(8'h16);
        end else if (corrupt) begin
            ev_q.push_back('{2'b01, 1});
            rs_q.push_back(8'h15);
        end else begin
            for (int i = 0; i < int'(len); i++)
                wr_q.push_back('{6'(i), pay[i], i + 1});
            ev_q.push_back('{2'b10, int'(len) + 1});
            rs_q.push_back(8'h06);
        end
        send_byte(8'hA5, hold, 2);
        send_byte(c, hold, 2);
        send_byte(len, hold, 2);
        if (len <= 8'd40) begin
            for (int i = 0; i < int'(len); i++) send_byte(pay[i], hold, 2);
            send_byte(chk, hold, 2);
        end
    endtask

    task automatic wait_idle(output bit done);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        done = !busy;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd, cfg_data, cfg_index, tx_data} !== 30'd0) begin
            errors++;
            $display("FAIL reset_data got cmd=%02h data=%02h idx=%0d tx=%02h required all 0",
                     cmd, cfg_data, cfg_index, tx_data);
        end
        checks++;
        if ({cfg_wr, frame_done, frame_error, tx_send, busy} !== 5'd0) begin
            errors++;
            $display("FAIL reset_strobes got %b required 00000",
                     {cfg_wr, frame_done, frame_error, tx_send, busy});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %0b required 0", busy);
        end
    endtask

    task automatic test_good_frame();
        pay = '{8'h11, 8'h22};
        send_frame(8'h03, 8'd2, 1'b0, 1);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL good_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
        checks++;
        if (cmd !== 8'h03) begin
            errors++;
            $display("FAIL good_cmd got %02h required 03", cmd);
        end
    endtask

    task automatic test_bad_checksum();
        send_byte(8'h00, 1, 2);
        send_byte(8'hFF, 1, 2);
        send_byte(8'h5A, 1, 2);
        pay = '{8'h11, 8'h22};
        send_frame(8'h03, 8'd2, 1'b1, 1);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL badchk_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
    endtask

    task automatic test_length_overflow();
        pay.delete();
        send_frame(8'h01, 8'h29, 1'b0, 1);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL overflow_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
    endtask

    task automatic test_timeout();
        ev_q.push_back('{2'b01, 100});
        rs_q.push_back(8'h17);
        send_byte(8'hA5, 1, 2);
        send_byte(8'h03, 1, 2);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL timeout_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
    endtask

    // LEN byte lands in the very cycle the counter expires, so it must win
    task automatic test_timeout_edge();
        ev_q.push_back('{2'b10, 1});
        rs_q.push_back(8'h06);
        send_byte(8'hA5, 1, 2);
        send_byte(8'h03, 1, 97);
        send_byte(8'h00, 1, 2);
        send_byte(8'h03, 1, 2);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL timeout_edge_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
    endtask

    task automatic test_held_rx_and_reset();
        send_byte(8'hA5, 3, 2);
        send_byte(8'h07, 3, 2);
        send_byte(8'h03, 3, 2);
        send_byte(8'hAA, 3, 2);
        send_byte(8'hBB, 3, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (cmd !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got cmd=%02h busy=%0b required cmd=00 busy=0", cmd, busy);
        end
        pay.delete();
        send_frame(8'h07, 8'd0, 1'b0, 3);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL held_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
        checks++;
        if (cmd !== 8'h07) begin
            errors++;
            $display("FAIL held_cmd got %02h required 07", cmd);
        end
    endtask

    task automatic test_tx_backpressure();
        tx_block = 1'b1;
        pay = '{8'h5C};
        send_frame(8'h09, 8'd1, 1'b0, 1);
        send_byte(8'hA5, 1, 2);
        send_byte(8'h09, 1, 2);
        send_byte(8'h01, 1, 2);
        send_byte(8'h5C, 1, 2);
        send_byte(8'h54, 1, 2);
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (rs_q.size() != 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_held got resp_pending=%0d busy=%0b required resp_pending=1 busy=1",
                     rs_q.size(), busy);
        end
        tx_block = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL bp_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
    endtask

    task automatic test_back_to_back();
        pay.delete();
        for (int i = 0; i < 40; i++) pay.push_back(8'($urandom));
        send_frame(8'h42, 8'd40, 1'b0, 1);
        wait_idle(ok);
        pay = '{8'h7E};
        send_frame(8'h43, 8'd1, 1'b0, 2);
        wait_idle(ok);
        checks++;
        if (!ok || pending() != 0) begin
            errors++;
            $display("FAIL b2b_drain got idle=%0b pending=%0d required idle=1 pending=0", ok, pending());
        end
        checks++;
        if (cmd !== 8'h43) begin
            errors++;
            $display("FAIL b2b_cmd got %02h required 43", cmd);
        end
    endtask

    initial begin
        fork
            cycle_loop();
            tx_model();
            mon_loop();
        join_none
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_length_overflow();
        test_timeout();
        test_timeout_edge();
        test_held_rx_and_reset();
        test_tx_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish required finish errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 40: maximum payload bytes per frame; legal range 1..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: inter-byte timeout in clk cycles.
REQ-003 SHALL have parameter SYNC, default 8'hA5: frame start byte.
REQ-004 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: rx_data  in  8  byte from UART receiver.
REQ-007 Port: rx_new  in  1  new-byte flag from UART receiver; may stay high for several cycles.
REQ-008 Port: cmd  out  8  command byte of the current or last frame.
REQ-009 Port: cfg_data  out  8  payload byte to configuration storage.
REQ-010 Port: cfg_index  out  6  payload byte index, 0-based.
REQ-011 Port: cfg_wr  out  1  one-cycle write strobe for cfg_data/cfg_index.
REQ-012 Port: frame_done  out  1  one-cycle pulse after a valid frame is fully written.
REQ-013 Port: frame_error  out  1  one-cycle pulse on a rejected frame.
REQ-014 Port: tx_data  out  8  response byte to UART transmitter.
REQ-015 Port: tx_send  out  1  one-cycle transmit request.
REQ-016 Port: tx_ready  in  1  transmitter idle; goes low while it sends.
REQ-017 Port: busy  out  1  high in every state except IDLE.

Function
REQ-018 A byte SHALL be accepted only on a rising edge of rx_new, i.e. rx_new=1 now and 0 on the previous cycle; rx_data is sampled in that same cycle.
REQ-019 Frame format SHALL be SYNC, CMD, LEN, LEN payload bytes, then CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-020 States SHALL be IDLE, CMD, LEN, PAYLOAD, CHECK, WRITE, DONE, RESP, RESP_HOLD.
REQ-021 IDLE: accepted byte == SYNC -> CMD; any other byte is discarded silently.
REQ-022 CMD: accepted byte -> cmd register -> LEN; cmd SHALL hold its value until the next frame's CMD byte.
REQ-023 LEN: LEN > MAX_LEN -> frame_error, response 8'h16; LEN == 0 -> CHECK; otherwise -> PAYLOAD.
REQ-024 PAYLOAD: each byte SHALL be stored into an internal MAX_LEN x 8 buffer at the running index; after byte LEN -> CHECK.
REQ-025 No cfg_wr SHALL occur before the checksum is validated.
REQ-026 CHECK, on accepted byte in cycle N:
- mismatch -> frame_error in cycle N+1, response 8'h15.
- match -> WRITE, with cfg_wr high in cycles N+1..N+LEN at cfg_index 0..LEN-1 with buffered data, one write per cycle, no gaps.
- frame_done in cycle N+LEN+1; with LEN=0, frame_done in N+1 and no cfg_wr.
- response 8'h06.
REQ-027 Timeout: in CMD, LEN, PAYLOAD or CHECK, a counter SHALL count cycles since the last accepted byte.
- count reaching TIMEOUT_CYCLES -> frame_error, response 8'h17.
- a byte edge in the same cycle as expiry wins; the counter clears.
REQ-028 RESP: tx_data SHALL hold the response code; tx_send SHALL pulse one cycle on the first cycle with tx_ready=1 -> RESP_HOLD.
REQ-029 RESP_HOLD: wait for tx_ready=0, then -> IDLE; tx_send SHALL never assert twice per frame.
REQ-030 Bytes accepted in WRITE, DONE, RESP or RESP_HOLD SHALL be dropped; they are not parsed as SYNC.
REQ-031 frame_error and the first cfg_wr SHALL never coincide; frame_done and frame_error are mutually exclusive per frame.

Reset
REQ-032 rst=1 SHALL force IDLE on the next clock edge, from any state including mid-frame or mid-WRITE.
REQ-033 While rst=1 the parser SHALL accept no bytes.
REQ-034 Reset values: cmd, cfg_data, cfg_index, tx_data = 0; cfg_wr, frame_done, frame_error, tx_send, busy = 0; timeout counter and rx_new edge register = 0.
REQ-035 Buffer contents need not be reset; any stale contents SHALL be unobservable.

Verification
REQ-036 Good frame A5 03 02 11 22 32 -> cfg_wr (idx0,0x11) then (idx1,0x22) on consecutive cycles; cmd=0x03; frame_done; one tx_send with tx_data=0x06.
REQ-037 Bad checksum A5 03 02 11 22 33 -> no cfg_wr, frame_error, tx_data=0x15; preceding bytes 00 FF 5A before A5 ignored.
REQ-038 Length overflow A5 01 29 (41 > MAX_LEN=40) -> frame_error, tx_data=0x16, parser back in IDLE.
REQ-039 TIMEOUT_CYCLES=100: A5 03 then silence -> frame_error exactly 100 cycles after the 03 edge, tx_data=0x17.
REQ-040 rx_new held high 3 cycles per byte -> each byte counted once; rst pulsed mid-payload, then frame A5 07 00 07 -> frame_done, no cfg_wr, tx_data=0x06.
REQ-041 tx_ready held low 50 cycles when the response is due -> tx_send delayed until tx_ready=1; bytes received meanwhile dropped.
